// File: rtl/issue_ctrl_pkg.sv
// issue_pkg: opcode values shared with the ALU, sequencer states and instruction field positions.
// rev 1.0
`default_nettype none

package issue_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 4;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_OUTW = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int IMMF_B = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 18;
  localparam int RSV_HI = 17;
  localparam int RSV_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    OUT    = 3'd4,
    RETIRE = 3'd5,
    HALT   = 3'd6
  } state_e;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHR) || (op == OP_SHL) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_ctrl_regfile.sv
// regfile: NREG x 32 registers, two combinational reads, one synchronous write; R0 is never written.
// rev 1.0
`default_nettype none

module regfile
  import issue_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1_i,
  output logic [XLEN-1:0]   rd1_o,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [XLEN-1:0]   rd2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // R0 stays at its reset value of zero since writes to it are suppressed
  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];

endmodule

`default_nettype wire

// File: rtl/issue_ctrl.sv
// issue_ctrl: fetch/decode/issue sequencer driving an external ALU, with output port and HALT.
// Optional retired-instruction counter enabled by ISSUE_CTRL_RETIRE_CNT_EN. rev 1.0
`default_nettype none

module issue_ctrl
  import issue_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic            alu_en,
  output logic            alu_has_imm,
  output logic [4:0]      alu_opcode,
  output logic [31:0]     alu_x1,
  output logic [31:0]     alu_x2,
  output logic [15:0]     alu_imm,
  input  logic [31:0]     alu_y,
  output logic            out_valid,
  output logic [31:0]     out_data,
  input  logic            out_ready,
  output logic            halted,
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
  output logic [31:0]     retired_cnt,
`endif
  output logic            illegal
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [4:0]        opc_q;
  logic              immf_q;
  logic [REG_AW-1:0] rd_q, rs_q;
  logic [15:0]       imm_q;
  logic [XLEN-1:0]   x1_q, x2_q, res_q;
  logic              imem_req_q, alu_en_q, out_valid_q, halted_q, illegal_q;
  logic [XLEN-1:0]   rf_rs, rf_rd;
  logic              rf_we;
  logic              unused_rsvd;

  assign unused_rsvd = ^imem_data[RSV_HI:RSV_LO];
  assign pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign rf_we       = (state_q == WB);

  regfile #(.NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs_q),
    .rd1_o (rf_rs),
    .ra2_i (rd_q),
    .rd2_o (rf_rd),
    .we_i  (rf_we),
    .wa_i  (rd_q),
    .wd_i  (res_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      opc_q       <= '0;
      immf_q      <= 1'b0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      res_q       <= '0;
      imem_req_q  <= 1'b1;
      alu_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_valid) begin
            opc_q      <= imem_data[OPC_HI:OPC_LO];
            immf_q     <= imem_data[IMMF_B];
            rd_q       <= imem_data[RD_HI:RD_LO];
            rs_q       <= imem_data[RS_HI:RS_LO];
            imm_q      <= imem_data[IMM_HI:IMM_LO];
            imem_req_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          x1_q <= rf_rs;
          x2_q <= rf_rd;
          if (is_alu_op(opc_q)) begin
            alu_en_q <= 1'b1;
            state_q  <= EXEC;
          end else if (opc_q == OP_OUTW) begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (opc_q == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            if (opc_q != OP_NOP) illegal_q <= 1'b1;
            state_q <= RETIRE;
          end
        end
        EXEC: begin
          res_q    <= alu_y;
          alu_en_q <= 1'b0;
          state_q  <= WB;
        end
        WB: state_q <= RETIRE;
        OUT: begin
          // word and valid stay frozen until the consumer takes them
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= RETIRE;
          end
        end
        RETIRE: begin
          pc_q       <= pc_d;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef ISSUE_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if ((state_q == RETIRE) || ((state_q == DECODE) && (opc_q == OP_HALT))) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign alu_en      = alu_en_q;
  assign alu_has_imm = immf_q;
  assign alu_opcode  = opc_q;
  assign alu_x1      = x1_q;
  assign alu_x2      = x2_q;
  assign alu_imm     = imm_q;
  assign out_valid   = out_valid_q;
  assign out_data    = x2_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed vector table, hand-written corner sequences,
// and random programs compared against an instruction-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_issue_ctrl;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_OUTW = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [31:0] HALTW  = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b1;
  logic [31:0] imem_data;
  logic        alu_en, alu_has_imm;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_x1, alu_x2, alu_y;
  logic [15:0] alu_imm;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic        halted, illegal;
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  logic [31:0] mem [256];
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic        exp_ill;
  int          exp_ret;
  int          pp;
  bit          rand_valid = 1'b0, rand_ready = 1'b0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SHR: return a >> b;
      OP_SHL: return a << b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_y     = alu_ref(alu_opcode, alu_x2, alu_has_imm ? {16'h0, alu_imm} : alu_x1);
  assign imem_data = mem[imem_addr[7:0]];

  issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .alu_en      (alu_en),
    .alu_has_imm (alu_has_imm),
    .alu_opcode  (alu_opcode),
    .alu_x1      (alu_x1),
    .alu_x2      (alu_x2),
    .alu_imm     (alu_imm),
    .alu_y       (alu_y),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .halted      (halted),
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .illegal     (illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs are finalised at a falling edge; a transfer is logged when the next rising edge will take it.
  task automatic cyc();
    if (rand_valid) imem_valid = ($urandom_range(0, 3) != 0);
    else imem_valid = 1'b1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic hi, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm);
    return {op, hi, rd, rs, 2'b00, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALTW;
    pp = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    mem[pp] = w;
    pp++;
  endtask

  task automatic load(input logic [3:0] r, input logic [31:0] v);
    if (r != 4'd0) begin
      emit(enc(OP_ADD, 1'b1, r, 4'd0, v[31:16]));
      emit(enc(OP_SHL, 1'b1, r, 4'd0, 16'd16));
      emit(enc(OP_OR,  1'b1, r, 4'd0, v[15:0]));
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    for (int c = 0; c < budget && !halted; c++) cyc();
    chk({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  // Instruction-level interpretation of the program image.
  task automatic model_run();
    logic [31:0] r [16];
    logic [31:0] w, src;
    logic [7:0]  pc;
    for (int i = 0; i < 16; i++) r[i] = 32'h0;
    exp_q.delete();
    exp_ill = 1'b0;
    exp_ret = 0;
    pc = 8'd0;
    for (int n = 0; n < 256; n++) begin
      w   = mem[pc];
      src = w[26] ? {16'h0, w[15:0]} : r[w[21:18]];
      exp_ret++;
      if (w[31:27] == OP_HALT) break;
      case (w[31:27])
        OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR, OP_XOR:
          if (w[25:22] != 4'd0) r[w[25:22]] = alu_ref(w[31:27], r[w[25:22]], src);
        OP_OUTW: exp_q.push_back(r[w[25:22]]);
        OP_NOP: ;
        default: exp_ill = 1'b1;
      endcase
      pc++;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        hi;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic [31:0] vrd;
    logic [31:0] vrs;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t vt [16];
  logic [4:0] ill_ops [8];
  logic [4:0] alu_ops [7];

  initial begin
    int en_cnt, stable, hcnt;

    vt[0]  = '{OP_ADD,  1'b0, 4'd1,  4'd2,  16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vt[1]  = '{OP_ADD,  1'b1, 4'd1,  4'd2,  16'hFFFF, 32'h1234_5678, 32'h0000_DEAD, 32'h1235_5677, 1'b0};
    vt[2]  = '{OP_SUB,  1'b0, 4'd3,  4'd4,  16'h0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vt[3]  = '{OP_SUB,  1'b1, 4'd3,  4'd4,  16'h0001, 32'h0001_0000, 32'h0000_0000, 32'h0000_FFFF, 1'b0};
    vt[4]  = '{OP_SHR,  1'b0, 4'd5,  4'd6,  16'h0000, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0};
    vt[5]  = '{OP_SHR,  1'b0, 4'd5,  4'd6,  16'h0000, 32'h8000_0000, 32'd32,        32'h0000_0000, 1'b0};
    vt[6]  = '{OP_SHL,  1'b0, 4'd2,  4'd3,  16'h0000, 32'h0000_0001, 32'd40,        32'h0000_0000, 1'b0};
    vt[7]  = '{OP_SHL,  1'b1, 4'd7,  4'd8,  16'h0004, 32'h0000_ABCD, 32'h0000_0000, 32'h000A_BCD0, 1'b0};
    vt[8]  = '{OP_AND,  1'b1, 4'd8,  4'd9,  16'hFF00, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_BE00, 1'b0};
    vt[9]  = '{OP_OR,   1'b0, 4'd9,  4'd10, 16'h0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0};
    vt[10] = '{OP_XOR,  1'b0, 4'd15, 4'd14, 16'h0000, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0};
    vt[11] = '{OP_ADD,  1'b1, 4'd0,  4'd1,  16'h0005, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b0};
    vt[12] = '{OP_ADD,  1'b0, 4'd1,  4'd1,  16'h0000, 32'h0000_0003, 32'h0000_0003, 32'h0000_0006, 1'b0};
    vt[13] = '{5'b00001, 1'b1, 4'd1, 4'd2,  16'h0005, 32'h0000_0007, 32'h0000_0001, 32'h0000_0007, 1'b1};
    vt[14] = '{OP_NOP,  1'b1, 4'd1,  4'd2,  16'h0009, 32'h0000_0011, 32'h0000_0001, 32'h0000_0011, 1'b0};
    vt[15] = '{OP_SUB,  1'b0, 4'd1,  4'd0,  16'h0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0};
    ill_ops = '{5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b01100, 5'b01110, 5'b10000, 5'b11110};
    alu_ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR, OP_XOR};

    @(negedge clk);

    // Reset state and zero-wait timing of two back-to-back ALU instructions
    clear_mem();
    emit(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 16'd5));
    emit(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 16'd7));
    emit(enc(OP_OUTW, 1'b0, 4'd1, 4'd0, 16'd0));
    emit(HALTW);
    got_q.delete();
    reset_dut();
    chk("reset_fetch", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'd0});
    chk("reset_flags", {28'd0, alu_en, out_valid, halted, illegal}, 32'd0);
    chk("reset_alu_fields", {10'd0, alu_has_imm, alu_opcode, alu_imm}, 32'd0);
    chk("reset_x1", alu_x1, 32'd0);
    chk("reset_x2", alu_x2, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
    chk("reset_retired_cnt", retired_cnt, 32'd0);
`endif
    en_cnt = 0;
    for (int c = 1; c <= 11; c++) begin
      en_cnt += int'(alu_en);
      if (c == 3) chk("exec1_alu_en", {31'd0, alu_en}, 32'd1);
      if (c == 5) chk("retire1_addr", {15'd0, imem_req, imem_addr}, {15'd0, 1'b0, 16'd0});
      if (c == 6) chk("fetch2_cycle6", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'd1});
      if (c == 8) chk("exec2_operands", {alu_en, alu_has_imm, alu_x2[13:0], alu_imm}, {1'b1, 1'b1, 14'd5, 16'd7});
      cyc();
    end
    chk("alu_en_cycles", en_cnt, 32'd2);
    run_to_halt("timing", 200);
    chk("timing_out_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("timing_r1", got_q[0], 32'd12);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      clear_mem();
      load(vt[i].rd, vt[i].vrd);
      if (vt[i].rs != vt[i].rd) load(vt[i].rs, vt[i].vrs);
      emit(enc(vt[i].op, vt[i].hi, vt[i].rd, vt[i].rs, vt[i].imm));
      emit(enc(OP_OUTW, 1'b0, vt[i].rd, 4'd0, 16'd0));
      emit(HALTW);
      got_q.delete();
      reset_dut();
      run_to_halt($sformatf("vec%0d", i), 500);
      chk($sformatf("vec%0d_count", i), got_q.size(), 32'd1);
      if (got_q.size() > 0) chk($sformatf("vec%0d_result", i), got_q[0], vt[i].exp);
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].ill});
    end

    // OUTW held off by out_ready for four cycles
    clear_mem();
    load(4'd1, 32'hA5A5_A5A5);
    emit(enc(OP_OUTW, 1'b0, 4'd1, 4'd0, 16'd0));
    emit(HALTW);
    got_q.delete();
    out_ready = 1'b0;
    reset_dut();
    for (int c = 0; c < 100 && !out_valid; c++) cyc();
    chk("stall_out_seen", {31'd0, out_valid}, 32'd1);
    stable = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid && out_data == 32'hA5A5_A5A5 && imem_addr == 16'd3) stable++;
      if (k == 4) out_ready = 1'b1;
      cyc();
    end
    chk("stall_valid_cycles", stable, 32'd5);
    chk("stall_after_accept", {15'd0, out_valid, imem_addr}, {15'd0, 1'b0, 16'd3});
    cyc();
    chk("stall_pc_advanced", {16'd0, imem_addr}, 32'd4);
    chk("stall_out_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("stall_out_word", got_q[0], 32'hA5A5_A5A5);
    run_to_halt("stall", 100);

    // HALT at address 3
    clear_mem();
    emit(32'h0); emit(32'h0); emit(32'h0);
    emit(HALTW);
    reset_dut();
    for (int c = 1; c < 12; c++) begin
      if (c == 11) chk("halt_not_yet", {31'd0, halted}, 32'd0);
      cyc();
    end
    chk("halt_entered", {30'd0, halted, imem_req}, {30'd0, 1'b1, 1'b0});
    hcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (halted && !imem_req) hcnt++;
      cyc();
    end
    chk("halt_sticky", hcnt, 32'd8);
    chk("halt_no_illegal", {31'd0, illegal}, 32'd0);
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
    chk("halt_retired_cnt", retired_cnt, 32'd4);
`endif

    // Reset during an OUT stall
    clear_mem();
    emit(enc(OP_ADD, 1'b1, 4'd1, 4'd0, 16'd9));
    emit(enc(OP_OUTW, 1'b0, 4'd1, 4'd0, 16'd0));
    emit(HALTW);
    got_q.delete();
    out_ready = 1'b0;
    reset_dut();
    for (int c = 0; c < 100 && !out_valid; c++) cyc();
    chk("rst_stall_out_seen", {31'd0, out_valid}, 32'd1);
    cyc(); cyc();
    rst_n = 1'b0;
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    chk("rst_stall_state", {14'd0, out_valid, halted, imem_req, imem_addr[12:0]}, {14'd0, 1'b0, 1'b0, 1'b1, 13'd0});
    chk("rst_stall_no_xfer", got_q.size(), 32'd0);
    run_to_halt("rst_stall", 200);
    chk("rst_stall_out_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("rst_stall_regs_cleared", got_q[0], 32'd9);

    // Random programs with random fetch waits and output back-pressure
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      clear_mem();
      for (int n = 0; n < 30; n++) begin
        logic [31:0] w;
        int          sel;
        sel = $urandom_range(0, 15);
        w = $urandom;
        w[25:22] = 4'($urandom_range(0, 7));
        w[21:18] = 4'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) w[15:0] = 16'($urandom_range(0, 40));
        if (sel == 0)       w[31:27] = OP_NOP;
        else if (sel <= 7)  w[31:27] = alu_ops[sel-1];
        else if (sel <= 9)  w[31:27] = OP_OUTW;
        else if (sel == 10) w[31:27] = ill_ops[$urandom_range(0, 7)];
        else begin
          w[31:27] = (sel[0]) ? OP_ADD : OP_OR;
          w[26] = 1'b1;
        end
        emit(w);
      end
      for (int r = 1; r < 8; r++) emit(enc(OP_OUTW, 1'b0, 4'(r), 4'd0, 16'd0));
      emit(HALTW);
      model_run();
      got_q.delete();
      reset_dut();
      run_to_halt($sformatf("rnd%0d", it), 5000);
      chk($sformatf("rnd%0d_count", it), got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        chk($sformatf("rnd%0d_out%0d", it, k), got_q[k], exp_q[k]);
      chk($sformatf("rnd%0d_illegal", it), {31'd0, illegal}, {31'd0, exp_ill});
`ifdef ISSUE_CTRL_RETIRE_CNT_EN
      chk($sformatf("rnd%0d_retired", it), retired_cnt, exp_ret);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
